// File: rtl/multi_button_counter_pkg.sv
// Shared types and default timing constants for the multi-channel debounced button counter.
package multi_button_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    PRESSED,
    ARM_RELEASE
  } deb_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 600000;
  localparam int DEF_REPEAT_CYCLES   = 6000000;

endpackage

// File: rtl/multi_button_counter_if.sv
// Pin-side and count-side signals of the button counter, with modports for driver and counter.
interface multi_button_counter_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 4
);

  logic [N_CH-1:0]       btn_n;
  logic [N_CH-1:0]       dir;
  logic                  wrap_en;
  logic                  clr;
  logic [N_CH-1:0]       held;
  logic [N_CH-1:0]       press_pulse;
  logic [N_CH-1:0]       release_pulse;
  logic [N_CH*CNT_W-1:0] count;

  modport master (
    output btn_n, dir, wrap_en, clr,
    input  held, press_pulse, release_pulse, count
  );

  modport slave (
    input  btn_n, dir, wrap_en, clr,
    output held, press_pulse, release_pulse, count
  );

endinterface

// File: rtl/multi_button_counter_btn_debounce.sv
// One button channel: 2-flop synchroniser, press/release debounce FSM and pulse outputs.
// Define AUTO_REPEAT_EN to add periodic press pulses while the button stays held.
module btn_debounce
  import multi_button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic press_evt_o
);

  localparam int            TW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("btn_debounce: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  deb_state_t    state_q;
  logic [TW-1:0] timer_q;
  logic          sync1_q, sync2_q;
  logic          held_q, press_q, release_q;
  logic          timer_done, rpt_fire;

  assign timer_done = (timer_q == T_LAST);

`ifdef AUTO_REPEAT_EN
  localparam int            RW     = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_q;
  assign rpt_fire = (state_q == PRESSED) && sync2_q && (rpt_q == R_LAST);
`else
  assign rpt_fire = 1'b0;
`endif

  // Exposed combinationally so the counter steps on the same edge that raises press_o.
  assign press_evt_o = ((state_q == ARM_PRESS) && sync2_q && timer_done) || rpt_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      timer_q   <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      sync1_q   <= ~btn_n_i;
      sync2_q   <= sync1_q;
      press_q   <= press_evt_o;
      release_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_q     <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= ARM_PRESS;
            timer_q <= '0;
          end
        end
        ARM_PRESS: begin
          if (!sync2_q) begin
            state_q <= IDLE;
          end else if (timer_done) begin
            state_q <= PRESSED;
            held_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2_q) begin
            state_q <= ARM_RELEASE;
            timer_q <= '0;
          end
`ifdef AUTO_REPEAT_EN
          else if (!rpt_fire) begin
            rpt_q <= rpt_q + 1'b1;
          end
`endif
        end
        ARM_RELEASE: begin
          if (sync2_q) begin
            state_q <= PRESSED;
          end else if (timer_done) begin
            state_q   <= IDLE;
            held_q    <= 1'b0;
            release_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign held_o    = held_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/multi_button_counter.sv
// N-channel debounced push-button counter with per-channel up/down wrap/saturate counters.
// Define AUTO_REPEAT_EN to enable auto-repeat press pulses in each debouncer.
module multi_button_counter
  import multi_button_counter_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input logic                  clk,
  input logic                  rst,
  multi_button_counter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (N_CH < 1 || CNT_W < 1) begin : g_bad_param
    $error("multi_button_counter: N_CH and CNT_W must be >= 1");
  end

  function automatic logic [CNT_W-1:0] count_step(input logic [CNT_W-1:0] cur,
                                                  input logic             down,
                                                  input logic             wrap);
    logic [CNT_W-1:0] nxt;
    if (!down) nxt = (cur == CNT_MAX) ? (wrap ? '0 : CNT_MAX) : cur + 1'b1;
    else       nxt = (cur == '0)      ? (wrap ? CNT_MAX : '0) : cur - 1'b1;
    return nxt;
  endfunction

  logic [N_CH-1:0]       held, press_p, rel_p, press_evt;
  logic [N_CH*CNT_W-1:0] count_flat;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;

    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .btn_n_i    (bus.btn_n[i]),
      .held_o     (held[i]),
      .press_o    (press_p[i]),
      .release_o  (rel_p[i]),
      .press_evt_o(press_evt[i])
    );

    // Clear takes priority over a press accepted in the same cycle.
    always_comb begin
      cnt_d = cnt_q;
      if (bus.clr)           cnt_d = '0;
      else if (press_evt[i]) cnt_d = count_step(cnt_q, bus.dir[i], bus.wrap_en);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign count_flat[i*CNT_W +: CNT_W] = cnt_q;
  end

  assign bus.held          = held;
  assign bus.press_pulse   = press_p;
  assign bus.release_pulse = rel_p;
  assign bus.count         = count_flat;

endmodule

// File: tb/tb_multi_button_counter.sv
// Scoreboard bench for multi_button_counter: a level-stability reference model predicts pulses.
module tb_multi_button_counter;

  localparam int N_CH  = 2;
  localparam int CNT_W = 4;
  localparam int DEB   = 4;
  localparam int RPT   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_button_counter_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  multi_button_counter #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(RPT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [N_CH-1:0]       press;
    logic [N_CH-1:0]       rel;
    logic [N_CH-1:0]       held;
    logic [N_CH*CNT_W-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: synchronised-level pipeline, debounced level, stability run length, counts.
  int m_p1[N_CH], m_p2[N_CH], m_held[N_CH], m_run[N_CH], m_rep[N_CH], m_cnt[N_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_count(input int c, input logic down, input logic wrap);
    int top;
    top = (1 << CNT_W) - 1;
    if (!down) return wrap ? (c + 1) % (top + 1) : ((c + 1 > top) ? top : c + 1);
    else       return wrap ? (c + top) % (top + 1) : ((c == 0) ? 0 : c - 1);
  endfunction

  function automatic logic [N_CH*CNT_W-1:0] model_count();
    logic [N_CH*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] model_held();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = (m_held[i] != 0);
    return v;
  endfunction

  task automatic model_step();
    exp_t e;
    int   s;
    bit   stable_before;
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        m_p1[i] = 0; m_p2[i] = 0; m_held[i] = 0; m_run[i] = 0; m_rep[i] = 0; m_cnt[i] = 0;
      end
      return;
    end
    e.press = '0;
    e.rel   = '0;
    for (int i = 0; i < N_CH; i++) begin
      s       = m_p2[i];
      m_p2[i] = m_p1[i];
      m_p1[i] = bus.btn_n[i] ? 0 : 1;
      stable_before = (m_run[i] == 0);
      if (s != m_held[i]) m_run[i]++;
      else                m_run[i] = 0;
      if (m_run[i] == DEB + 1) begin
        m_held[i] = s;
        m_run[i]  = 0;
        m_rep[i]  = 0;
        if (s != 0) e.press[i] = 1'b1;
        else        e.rel[i]   = 1'b1;
      end
`ifdef AUTO_REPEAT_EN
      else if (m_held[i] == 1 && s == 1 && stable_before) begin
        m_rep[i]++;
        if (m_rep[i] == RPT) begin
          m_rep[i]   = 0;
          e.press[i] = 1'b1;
        end
      end else begin
        m_rep[i] = 0;
      end
`endif
      if (bus.clr)         m_cnt[i] = 0;
      else if (e.press[i]) m_cnt[i] = next_count(m_cnt[i], bus.dir[i], bus.wrap_en);
    end
    e.held  = model_held();
    e.count = model_count();
    if ((e.press | e.rel) != '0) exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: every cycle with a DUT pulse or a predicted pulse consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((bus.press_pulse | bus.release_pulse) != '0 || exp_q.size() != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_press", 32'(bus.press_pulse), 32'(0));
          check("unexpected_release", 32'(bus.release_pulse), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("press_pulse", 32'(bus.press_pulse), 32'(e.press));
          check("release_pulse", 32'(bus.release_pulse), 32'(e.rel));
          check("held", 32'(bus.held), 32'(e.held));
          check("count", 32'(bus.count), 32'(e.count));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_ch(input int ch, input int hold);
    bus.btn_n[ch] = 1'b0;
    step(hold);
    bus.btn_n[ch] = 1'b1;
    step(DEB + 4);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_held"}, 32'(bus.held), 32'(0));
    check({tag, "_press"}, 32'(bus.press_pulse), 32'(0));
    check({tag, "_release"}, 32'(bus.release_pulse), 32'(0));
    check({tag, "_count"}, 32'(bus.count), 32'(0));
  endtask

  initial begin
    int rem[N_CH];
    int lvl[N_CH];

    rst         = 1'b1;
    bus.btn_n   = '1;
    bus.dir     = '0;
    bus.wrap_en = 1'b1;
    bus.clr     = 1'b0;
    step(3);
    check_all_zero("reset");
    rst = 1'b0;
    step(2);

    // Basic press/release and a short bounce that must be rejected.
    press_ch(0, DEB + 6);
    bus.btn_n[0] = 1'b0;
    step(3);
    bus.btn_n[0] = 1'b1;
    step(DEB + 4);
    check("bounce_count", 32'(bus.count), 32'(model_count()));
    check("bounce_held", 32'(bus.held), 32'(model_held()));

    // Wrap up, saturate up, saturate down, wrap down on channel 1.
    bus.wrap_en = 1'b1;
    repeat (17) press_ch(1, DEB + 3);
    bus.wrap_en = 1'b0;
    repeat (17) press_ch(1, DEB + 3);
    bus.dir[1] = 1'b1;
    repeat (17) press_ch(1, DEB + 3);
    bus.wrap_en = 1'b1;
    repeat (2) press_ch(1, DEB + 3);
    bus.dir[1] = 1'b0;

    // Clear coinciding with an accepted press.
    repeat (5) press_ch(0, DEB + 3);
    bus.clr = 1'b1;
    bus.btn_n[0] = 1'b0;
    step(DEB + 3);
    bus.clr = 1'b0;
    bus.btn_n[0] = 1'b1;
    step(DEB + 4);
    check("clr_count", 32'(bus.count), 32'(model_count()));

    // Reset in the middle of press debouncing on both channels.
    bus.btn_n = '0;
    step(3);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    step(2);
    rst = 1'b0;
    step(DEB + 6);
    bus.btn_n = '1;
    step(DEB + 4);

    // Long hold on channel 0.
    bus.btn_n[0] = 1'b0;
    step(DEB + 2 + 30);
    bus.btn_n[0] = 1'b1;
    step(DEB + 4);

    // Randomised pin activity with occasional direction, mode and clear changes.
    for (int i = 0; i < N_CH; i++) begin
      rem[i] = 1;
      lvl[i] = 1;
    end
    repeat (900) begin
      for (int i = 0; i < N_CH; i++) begin
        rem[i]--;
        if (rem[i] == 0) begin
          lvl[i] = 1 - lvl[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB))
                                               : int'($urandom_range(DEB + 2, DEB + 14));
          bus.btn_n[i] = (lvl[i] != 0);
        end
      end
      if ($urandom_range(0, 31) == 0) bus.dir = N_CH'($urandom);
      if ($urandom_range(0, 63) == 0) bus.wrap_en = ~bus.wrap_en;
      bus.clr = ($urandom_range(0, 49) == 0);
      step(1);
    end

    bus.clr   = 1'b0;
    bus.btn_n = '1;
    step(DEB + 12);
    check("final_count", 32'(bus.count), 32'(model_count()));
    check("final_held", 32'(bus.held), 32'(model_held()));
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_button_counter.md
Name: multi_button_counter

Overview:
Parametrised N-channel debounced push-button counter for board-level demos and user input. Each channel synchronises a raw active-low pin, debounces press and release with a stable-time timer, emits one-cycle press/release pulses and drives its own up/down counter with selectable wrap or saturate. Sits directly behind the PMOD/button pins; its count outputs drive LEDs or downstream logic.

Parameters:
N_CH, 2, number of independent button channels (>=1)
CNT_W, 4, width of each channel counter (>=1)
DEBOUNCE_CYCLES, 600000, clk cycles the synchronised level must be stable before a press/release is accepted (>=1)
REPEAT_CYCLES, 6000000, auto-repeat period in clk cycles; used only with AUTO_REPEAT_EN (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_n  input  N_CH  raw button pins, active-low, asynchronous to clk
dir  input  N_CH  per-channel direction: 0 = count up, 1 = count down
wrap_en  input  1  1 = counters wrap, 0 = counters saturate
clr  input  1  synchronous clear of all counters
held  output  N_CH  debounced pressed level per channel
press_pulse  output  N_CH  one-cycle pulse per accepted press (or repeat)
release_pulse  output  N_CH  one-cycle pulse per accepted release
count  output  N_CH*CNT_W  channel i counter at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (async, immediate, also mid-debounce): sync flops = released, FSM = IDLE, timer = 0, held = 0, press_pulse = 0, release_pulse = 0, count = 0.
- Per channel: btn = ~btn_n[i] through a 2-flop synchroniser; FSM input is the 2nd-flop output s.
- FSM states: IDLE, ARM_PRESS, PRESSED, ARM_RELEASE.
- IDLE: s=1 -> ARM_PRESS, timer <= 0.
- ARM_PRESS: s=0 -> IDLE (glitch rejected, no pulse). Otherwise timer++. When timer == DEBOUNCE_CYCLES-1 -> PRESSED, held <= 1, press_pulse <= 1 for exactly one cycle.
- PRESSED: s=0 -> ARM_RELEASE, timer <= 0.
- ARM_RELEASE: s=1 -> PRESSED (no pulse). When timer == DEBOUNCE_CYCLES-1 -> IDLE, held <= 0, release_pulse <= 1 for one cycle.
- Latency: raw pin stable-asserted from edge k: press_pulse and held rise at edge k+2+DEBOUNCE_CYCLES. Release symmetric.
- Timer width $clog2(DEBOUNCE_CYCLES+1); never overflows.
- Counter updates on the same edge that raises press_pulse, using dir[i] and wrap_en sampled that cycle: up from 2^CNT_W-1 -> 0 (wrap) or hold (saturate); down from 0 -> 2^CNT_W-1 (wrap) or hold 0 (saturate).
- clr and an accepted press in the same cycle: clr wins, count = 0; press_pulse still asserts.
- Channels fully independent; simultaneous presses on several channels all counted same cycle.
- Releases never change count.

Optional Feature:
AUTO_REPEAT_EN defined: in PRESSED, a repeat timer counts from 0 on entry; each time it reaches REPEAT_CYCLES-1 it reloads 0 and issues a press_pulse with a count step as for a normal press; leaving PRESSED clears it. Undefined: no repeat timer is built, exactly one press_pulse per debounced press, REPEAT_CYCLES ignored.

Decomposition:
- Package multi_button_counter_pkg: typedef deb_state_t enum {IDLE, ARM_PRESS, PRESSED, ARM_RELEASE}; default constants DEF_DEBOUNCE_CYCLES, DEF_REPEAT_CYCLES.
- Sub-module btn_debounce: one channel's synchroniser, FSM, timers, held/press/release outputs; instantiated N_CH times via generate. Counters and wrap/saturate logic live in the top.

Test Plan:
- N_CH=2, CNT_W=4, DEBOUNCE_CYCLES=4; btn_n[0] low from edge 10 -> press_pulse[0] high only at edge 16, held[0]=1, count[0]=1, count[1]=0.
- btn_n[0] low for 3 cycles then high (bounce) -> no press_pulse, count[0] unchanged, FSM back to IDLE.
- wrap_en=1, dir[1]=0, 16 presses on channel 1 -> count[1] 15 then 0; repeat with wrap_en=0 -> stays 15; dir[1]=1 from 0 with wrap_en=0 -> stays 0.
- clr=1 on the press_pulse[0] edge with count[0]=5 -> count[0]=0, press_pulse[0]=1; release after 4 stable cycles -> release_pulse[0] one cycle, count unchanged.
- rst asserted mid ARM_PRESS on both channels -> all outputs 0 immediately; after rst release, pin held low -> press after full 2+4 cycles again.
- AUTO_REPEAT_EN, REPEAT_CYCLES=8, button held 30 cycles past press -> 3 extra press_pulses 8 cycles apart, count[0]=4.
